// File: rtl/clock_period_meter.sv
// Measures the averaged period of a slow asynchronous square wave in clk_in cycles.
// Latency: valid pulses one cycle after the rising edge that completes a 2^AVG_LOG2 average; no backpressure.
module clock_period_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AVG_LOG2    = 2,
  parameter logic [31:0] TIMEOUT     = 32'd100_000_000
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sig_in,
  output logic [31:0] period_out,
  output logic [31:0] divider_out,
  output logic        valid,
  output logic        locked,
  output logic        timeout
);

  localparam int unsigned ACC_W     = 32 + AVG_LOG2;
  localparam logic [4:0]  LAST_SAMP = 5'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEASURE, ST_TIMEOUT} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [4:0]             nsamp_q, nsamp_d;
  logic [31:0]            period_q, period_d;
  logic [31:0]            divider_q, divider_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;

  logic                   rise_det;
  logic [31:0]            sample;
  logic [ACC_W-1:0]       sum;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d    = sync_q[SYNC_STAGES-1];
    rise_det  = sync_q[SYNC_STAGES-1] & ~prev_q;
    sample    = cnt_q + 32'd1;
    sum       = acc_q + ACC_W'(sample);

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    nsamp_d   = nsamp_q;
    period_d  = period_q;
    divider_d = divider_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    // Disable overrides any edge or completion in the same cycle; results hold.
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      acc_d     = '0;
      nsamp_d   = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (rise_det) begin
            cnt_d   = '0;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise_det) begin
            cnt_d = '0;
            if (nsamp_q == LAST_SAMP) begin
              period_d  = 32'(sum >> AVG_LOG2);
              divider_d = 32'(sum >> (AVG_LOG2 + 1));
              valid_d   = 1'b1;
              locked_d  = 1'b1;
              acc_d     = '0;
              nsamp_d   = '0;
            end else begin
              acc_d   = sum;
              nsamp_d = nsamp_q + 5'd1;
            end
          end else if (cnt_q == TIMEOUT - 32'd1) begin
            state_d   = ST_TIMEOUT;
            cnt_d     = '0;
            acc_d     = '0;
            nsamp_d   = '0;
            period_d  = '0;
            divider_d = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_TIMEOUT: begin
          if (rise_det) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
            state_d   = ST_MEASURE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      nsamp_q   <= '0;
      period_q  <= '0;
      divider_q <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      nsamp_q   <= nsamp_d;
      period_q  <= period_d;
      divider_q <= divider_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_out  = period_q;
  assign divider_out = divider_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed checks of averaging, timeout, minimum period and control interruptions.
module tb_clock_period_meter;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sig_in;
  logic [31:0] period_out;
  logic [31:0] divider_out;
  logic        valid;
  logic        locked;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int vcount = 0;
  int vlast  = 0;
  int vprev  = 0;
  int vsave  = 0;

  clock_period_meter #(
    .SYNC_STAGES(2),
    .AVG_LOG2   (2),
    .TIMEOUT    (32'd1000)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .period_out (period_out),
    .divider_out(divider_out),
    .valid      (valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clk_in cycle; outputs are sampled 1 ns after the edge and valid pulses are logged.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    if (valid === 1'b1) begin
      vcount++;
      vprev = vlast;
      vlast = cyc;
    end
  endtask

  task automatic period(input int p);
    sig_in = 1'b1;
    repeat (p / 2) step();
    sig_in = 1'b0;
    repeat (p - p / 2) step();
  endtask

  task automatic rearm();
    sig_in = 1'b0;
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    repeat (3) step();
    check("rst_period", period_out, 32'd0);
    check("rst_divider", divider_out, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    reset_n = 1'b1;
    step();
    enable = 1'b1;
    repeat (2) step();
    check("arm_locked", {31'd0, locked}, 32'd0);

    // Steady lock: arming edge plus four 100-cycle periods.
    repeat (4) period(100);
    check("lock_no_early_valid", vcount, 0);
    period(100);
    check("lock_valid_count", vcount, 1);
    check("lock_period", period_out, 32'd100);
    check("lock_divider", divider_out, 32'd50);
    check("lock_locked", {31'd0, locked}, 32'd1);
    repeat (4) period(100);
    check("repeat_valid_count", vcount, 2);
    check("repeat_spacing", vlast - vprev, 400);

    // Averaging: group 99,100,101,100 then 101,101,101,102.
    repeat (3) period(100);
    period(99); period(100); period(101); period(100);
    period(101);
    check("avg1_valid_count", vcount, 4);
    check("avg1_period", period_out, 32'd100);
    check("avg1_divider", divider_out, 32'd50);
    period(101); period(101); period(102);
    period(100);
    check("avg2_valid_count", vcount, 5);
    check("avg2_period", period_out, 32'd101);
    check("avg2_divider", divider_out, 32'd50);

    // Timeout and relock.
    sig_in = 1'b0;
    repeat (1000) step();
    check("tmo_timeout", {31'd0, timeout}, 32'd1);
    check("tmo_locked", {31'd0, locked}, 32'd0);
    check("tmo_period", period_out, 32'd0);
    check("tmo_divider", divider_out, 32'd0);
    check("tmo_no_valid", vcount, 5);
    period(100);
    check("relock_timeout_clear", {31'd0, timeout}, 32'd0);
    repeat (3) period(100);
    check("relock_no_early_valid", vcount, 5);
    period(100);
    check("relock_valid_count", vcount, 6);
    check("relock_period", period_out, 32'd100);
    check("relock_locked", {31'd0, locked}, 32'd1);

    // Timeout boundary: period 1000 accepted, 1001 times out.
    rearm();
    repeat (5) period(1000);
    check("bnd1000_valid_count", vcount, 7);
    check("bnd1000_period", period_out, 32'd1000);
    check("bnd1000_divider", divider_out, 32'd500);
    check("bnd1000_timeout", {31'd0, timeout}, 32'd0);
    rearm();
    period(1001);
    repeat (5) step();
    check("bnd1001_timeout", {31'd0, timeout}, 32'd1);
    check("bnd1001_no_valid", vcount, 7);
    check("bnd1001_period", period_out, 32'd0);

    // Minimum period of two cycles.
    rearm();
    repeat (8) period(2);
    sig_in = 1'b0;
    repeat (4) step();
    check("min_valid_count", vcount, 8);
    check("min_period", period_out, 32'd2);
    check("min_divider", divider_out, 32'd1);
    check("min_locked", {31'd0, locked}, 32'd1);

    // Enable dropped mid-average, then relock.
    rearm();
    repeat (5) period(100);
    check("ctl_lock_period", period_out, 32'd100);
    vsave = vcount;
    repeat (2) period(100);
    sig_in = 1'b1;
    repeat (10) step();
    enable = 1'b0;
    repeat (5) step();
    check("ctl_drop_no_valid", vcount, vsave);
    check("ctl_drop_locked", {31'd0, locked}, 32'd0);
    check("ctl_drop_period_hold", period_out, 32'd100);
    sig_in = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    repeat (2) step();
    repeat (4) period(100);
    check("ctl_reen_no_early_valid", vcount, vsave);
    check("ctl_reen_locked_early", {31'd0, locked}, 32'd0);
    period(100);
    check("ctl_reen_valid_count", vcount, vsave + 1);
    check("ctl_reen_period", period_out, 32'd100);
    check("ctl_reen_locked", {31'd0, locked}, 32'd1);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_period", period_out, 32'd0);
    check("arst_divider", divider_out, 32'd0);
    check("arst_locked", {31'd0, locked}, 32'd0);
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_timeout", {31'd0, timeout}, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measures the period of a slow external square wave against clk_in. The wave can be a clock_divider output, a sensor pulse train, or the heartbeat comparator output.
- Reports the averaged period in clk_in cycles, plus the equivalent divider value: divider = period / 2, using the same convention as our divider formula.
- Used for loopback checks of generated clocks and for rate measurement in the HeartAware datapath.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on sig_in; minimum 2.
- AVG_LOG2, 2: number of periods averaged per result = 2^AVG_LOG2; range 0..4.
- TIMEOUT, 100_000_000: clk_in cycles without a rising edge before timeout is declared (1 s at 100 MHz). Range 2..2^32-1.

Ports:
- clk_in, input, 1: system clock. All logic is on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: measurement enable.
- sig_in, input, 1: asynchronous signal under measurement.
- period_out, output, 32: averaged period in clk_in cycles.
- divider_out, output, 32: averaged period >> 1, i.e. the equivalent clock_divider divider.
- valid, output, 1: one-cycle pulse when period_out and divider_out update.
- locked, output, 1: at least one full average has completed since arming and no timeout has occurred since.
- timeout, output, 1: no edge seen within TIMEOUT cycles. Stays high until the next rising edge or until enable goes low.

Behaviour:
- Reset: while reset_n is low, all outputs, sync flops, the edge register, the counter, the accumulator and the sample count are 0; state = IDLE. Reset takes effect immediately, without waiting for a clock edge.
- Input path:
  - sig_in passes through SYNC_STAGES flops, then a previous-value register.
  - rise_det = sync_out & ~prev (combinational), so rise_det occurs SYNC_STAGES+1 clk_in edges after sig_in rises.
  - Since prev resets to 0, a sig_in already high at reset release produces one rise_det. This is harmless because the first edge only arms the meter.
- States:
  - IDLE: entered when enable = 0. cnt, accumulator and sample count are cleared. locked = 0, timeout = 0. period_out and divider_out hold their last values. When enable = 1, go to ARM.
  - ARM: wait for rise_det. On rise_det, cnt <= 0 and go to MEASURE.
  - MEASURE: cnt increments every cycle.
    - On rise_det: sample = cnt + 1, acc <= acc + sample, nsamp <= nsamp + 1, cnt <= 0.
    - When the accepted sample is number 2^AVG_LOG2: period_out <= (acc + sample) >> AVG_LOG2, divider_out <= (acc + sample) >> (AVG_LOG2 + 1), valid = 1 for one cycle, locked <= 1. acc and nsamp clear in the same cycle.
    - If there is no rise_det and cnt == TIMEOUT-1, go to TIMEOUT.
  - TIMEOUT: timeout = 1, locked = 0, period_out = 0, divider_out = 0, acc and nsamp cleared. On rise_det: cnt <= 0, timeout <= 0, go to MEASURE. That edge acts as the new arming edge.
- Arithmetic:
  - cnt is 32 bits and never exceeds TIMEOUT-1, so sample ≤ TIMEOUT.
  - The accumulator is 32 + AVG_LOG2 bits and never overflows.
  - Shifts truncate; no rounding.
- Latency: valid is asserted in the cycle after the rise_det that completes the average.
- Simultaneous events:
  - rise_det in the same cycle cnt == TIMEOUT-1: the edge wins. sample = TIMEOUT is accepted and there is no timeout.
  - enable = 0 in the same cycle as rise_det or completion: enable wins. Go to IDLE, no valid pulse, outputs hold.
  - reset_n low mid-measurement: immediate clear as in Reset.
- Minimum measurable period is 2 cycles (sig_in toggling every clk_in cycle). High/low duty cycle is irrelevant; only rising edges are used.

Test Plan:
All scenarios use SYNC_STAGES = 2, AVG_LOG2 = 2, TIMEOUT = 1000, and sig_in driven synchronously to clk_in unless noted.
1. Steady lock: enable = 1; sig_in square wave, 50 high / 50 low.
   - Required: first valid after the arming edge plus 4 periods, with period_out = 100, divider_out = 50, locked = 1.
   - Required: valid then repeats every 400 cycles.
2. Averaging and truncation:
   - Periods 99, 100, 101, 100 → period_out = 100, divider_out = 50.
   - Periods 101, 101, 101, 102 → period_out = 101 (405 >> 2), divider_out = 50 (405 >> 3).
3. Timeout and relock: after lock, hold sig_in low for 1000 cycles.
   - Required: timeout = 1, locked = 0, period_out = 0, divider_out = 0, no valid.
   - Restart the 100-cycle wave. Required: timeout clears on the first edge; valid with period_out = 100 after 4 further periods.
4. Timeout boundary:
   - Period exactly 1000 → valid, period_out = 1000, timeout stays 0.
   - Period 1001 → timeout = 1 with no valid.
5. Minimum period: sig_in toggles every cycle → period_out = 2, divider_out = 1, locked = 1.
6. Control interruptions:
   - Drop enable mid-average: no valid, locked = 0, period_out holds 100.
   - Re-enable: relock after the arming edge plus 4 periods.
   - Assert reset_n low asynchronously (between clk_in edges): all outputs read 0 before the next clk_in edge.
